xs3_word_decoder: RTL and testbench

Sequential excess-3 decoder: the receive end of our add-3 (excess-3) digit encoding. Accepts a stream of 4-bit excess-3 digits over a valid/ready handshake, most-significant digit first. Subtracts 3 from each digit and accumulates a fixed number of digits into one binary word. Each word is presented downstream over a second valid/ready handshake, with a sticky flag for invalid codes. Sits between the excess-3 encoder path and any binary consumer, and serves as a sequential benchmark alongside the combinational encoder testcases.

---
 rtl/xs3_word_decoder.sv | 94 +++++++++
 tb/tb_xs3_word_decoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/xs3_word_decoder.sv
// Sequential excess-3 decoder: accumulates NDIG excess-3 digits (MSD first) into one binary word.
// Define XS3_ERR_EN to enable invalid-code detection and the sticky out_err flag.
module xs3_word_decoder #(
  parameter int NDIG  = 3,
  parameter int OUT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_digit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_value,
  output logic             out_err
);

  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  localparam logic [0:0] ACC  = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] count;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] times_ten;
  logic [3:0]       d;
  logic [3:0]       contrib;
  logic             accept;

  assign in_ready  = (state == ACC);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;

  // acc*10 as shift-and-add, kept in OUT_W so truncation is implicit
  assign times_ten = (acc << 3) + (acc << 1);
  assign d         = in_digit - 4'd3;

`ifdef XS3_ERR_EN
  logic invalid;
  logic err;

  assign invalid = (in_digit < 4'd3) || (in_digit > 4'd12);
  assign contrib = invalid ? 4'd0 : d;
  assign out_err = err;

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (state == HOLD) begin
      if (out_ready) err <= 1'b0;
    end else if (accept) begin
      err <= err | invalid;
    end
  end
`else
  // Without detection every code wraps mod 16, e.g. 4'd2 contributes 15
  assign contrib = d;
  assign out_err = 1'b0;
`endif

  assign out_value = acc;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
      count <= '0;
      acc   <= '0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            acc <= times_ten + OUT_W'(contrib);
            if (count == LAST_DIG) begin
              count <= '0;
              state <= HOLD;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        default: begin
          if (out_ready) begin
            state <= ACC;
            acc   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xs3_word_decoder.sv
// Self-checking bench for xs3_word_decoder: directed test-plan words plus randomized
// handshake/reset traffic, compared against an arithmetic reference model.
module tb_xs3_word_decoder;

  localparam int NDIG  = 3;
  localparam int OUT_W = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_digit;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_value;
  logic             out_err;

  xs3_word_decoder #(.NDIG(NDIG), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_digit  (in_digit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int  digits[$];
  bit  m_hold      = 1'b0;
  bit  m_after_rst = 1'b0;
  int  m_val       = 0;
  bit  m_err       = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Decode a full word of raw excess-3 codes with plain arithmetic
  task automatic model_word(output int val, output bit err);
    val = 0;
    err = 1'b0;
    foreach (digits[i]) begin
      int  c;
      bit  bad;
`ifdef XS3_ERR_EN
      bad = (digits[i] < 3) || (digits[i] > 12);
`else
      bad = 1'b0;
`endif
      c   = bad ? 0 : ((digits[i] - 3 + 16) % 16);
      err = err | bad;
      val = (val * 10 + c) % (1 << OUT_W);
    end
  endtask

  task automatic check_outputs();
    check("in_ready",  int'(in_ready),  int'(!m_hold));
    check("out_valid", int'(out_valid), int'(m_hold));
    if (m_hold) begin
      check("out_value", int'(out_value), m_val);
      check("out_err",   int'(out_err),   int'(m_err));
    end
    if (m_after_rst) begin
      check("rst_value", int'(out_value), 0);
      check("rst_err",   int'(out_err),   0);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then check after the edge
  task automatic cycle(input logic r, input logic v, input logic [3:0] dig, input logic ordy);
    rst       = r;
    in_valid  = v;
    in_digit  = dig;
    out_ready = ordy;
    if (r) begin
      m_hold      = 1'b0;
      m_after_rst = 1'b1;
      digits.delete();
    end else begin
      m_after_rst = 1'b0;
      if (m_hold) begin
        if (ordy) m_hold = 1'b0;
      end else if (v) begin
        digits.push_back(int'(dig));
        if (digits.size() == NDIG) begin
          model_word(m_val, m_err);
          digits.delete();
          m_hold = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic word3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input int exp_val);
    cycle(1'b0, 1'b1, a, 1'b1);
    cycle(1'b0, 1'b1, b, 1'b1);
    cycle(1'b0, 1'b1, c, 1'b1);
    check("word_value", int'(out_value), exp_val);
    cycle(1'b0, 1'b0, 4'h0, 1'b1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_digit  = 4'h0;
    out_ready = 1'b0;

    cycle(1'b1, 1'b0, 4'h0, 1'b0);
    cycle(1'b0, 1'b0, 4'h0, 1'b0);

    // Basic, max, min
    word3(4'h4, 4'h5, 4'h6, 123);
    word3(4'hC, 4'hC, 4'hC, 999);
    word3(4'h3, 4'h3, 4'h3, 0);

    // Invalid code, then a clean word to show err clears
`ifdef XS3_ERR_EN
    word3(4'h4, 4'h2, 4'h6, 103);
`else
    word3(4'h4, 4'h2, 4'h6, 253);
`endif
    word3(4'h4, 4'h4, 4'h4, 111);

    // Backpressure with digits offered while holding
    cycle(1'b0, 1'b1, 4'h7, 1'b0);
    cycle(1'b0, 1'b1, 4'h8, 1'b0);
    cycle(1'b0, 1'b1, 4'h9, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 4'hA, 1'b0);
    check("bp_value", int'(out_value), 456);
    cycle(1'b0, 1'b1, 4'hA, 1'b1);
    word3(4'h4, 4'h5, 4'h6, 123);

    // Input gaps
    cycle(1'b0, 1'b1, 4'h5, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 4'h5, 1'b1);
    cycle(1'b0, 1'b1, 4'h6, 1'b1);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 4'h6, 1'b1);
    cycle(1'b0, 1'b1, 4'h7, 1'b1);
    check("gap_value", int'(out_value), 234);
    cycle(1'b0, 1'b0, 4'h0, 1'b1);

    // Reset mid-word
    cycle(1'b0, 1'b1, 4'h9, 1'b1);
    cycle(1'b0, 1'b1, 4'h9, 1'b1);
    cycle(1'b1, 1'b1, 4'h9, 1'b1);
    word3(4'h4, 4'h4, 4'h5, 112);

    // Reset while a word is held
    cycle(1'b0, 1'b1, 4'h8, 1'b0);
    cycle(1'b0, 1'b1, 4'h8, 1'b0);
    cycle(1'b0, 1'b1, 4'h8, 1'b0);
    cycle(1'b1, 1'b0, 4'h0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(logic'($urandom_range(0, 99) == 0),
            logic'($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 15)),
            logic'($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
